// File: rtl/dog_pkg.sv
// Shared types and constants for the dog sprite overlay.
package dog_pkg;

    localparam int          DOG_W               = 140;
    localparam int          DOG_H               = 177;
    localparam logic [11:0] DOG_TRANSPARENT     = 12'hF0F;
    localparam int          DOG_FRAMES_PER_STEP = 8;

    // Encodings are the frame-select values expected by the sprite ROM.
    typedef enum logic [1:0] {
        ANIM_IDLE   = 2'b00,
        ANIM_THROW1 = 2'b01,
        ANIM_THROW2 = 2'b10
    } anim_state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

    // True when pos lies in [start, start+len-1]. The upper bound is formed
    // in 12 bits so a sprite hanging past 2047 is clipped instead of wrapping.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] start,
                                     input logic [11:0] len);
        logic [11:0] last;
        last = {1'b0, start} + len - 12'd1;
        return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} <= last);
    endfunction

endpackage

// File: rtl/dog_draw_if.sv
// Pixel-stream, position, ROM and control signals of the dog overlay.
interface dog_draw_if;

    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        throw_start;
    logic [14:0] rom_addr;
    logic [1:0]  rom_state;
    logic [11:0] rom_rgb;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic        busy;

    // Upstream side: timing chain, position source and the sprite ROM.
    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
        output rgb_in, xpos, ypos, throw_start, rom_rgb,
        input  rom_addr, rom_state,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        input  rgb_out, busy
    );

    // The overlay block itself.
    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  rgb_in, xpos, ypos, throw_start, rom_rgb,
        output rom_addr, rom_state,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        output rgb_out, busy
    );

endinterface

// File: rtl/dog_anim_fsm.sv
// Throw animation sequencer: advances only on frame ticks (vblank rise) so
// a whole frame is always drawn with one ROM frame select.
module dog_anim_fsm
    import dog_pkg::*;
#(
    parameter int FRAMES_PER_STEP = DOG_FRAMES_PER_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vblnk,
    input  logic        i_throw_start,
    output anim_state_t o_state,
    output logic        o_busy
);

    localparam int              CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    anim_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_vblnk_d;
    logic             w_tick;

    assign w_tick = i_vblnk & ~r_vblnk_d;

    // State, counter, pending request and the vblank edge-detect copy.
    // NOTE: asynchronous reset must appear in the sensitivity list; sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ANIM_IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_vblnk_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_vblnk_d <= i_vblnk;
        end
    end

    // Next-state logic; a request arriving with a tick is only latched.
    always_comb begin
        // NOTE: hold values assigned first so no path leaves a variable unassigned (no latch).
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        unique case (r_state)
            ANIM_IDLE: begin
                if (w_tick && r_pending) begin
                    w_state_nxt   = ANIM_THROW1;
                    w_cnt_nxt     = '0;
                    w_pending_nxt = 1'b0;
                end else if (i_throw_start && !r_pending) begin
                    w_pending_nxt = 1'b1;
                end
            end
            ANIM_THROW1: begin
                if (w_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ANIM_THROW2;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ANIM_THROW2: begin
                if (w_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ANIM_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ANIM_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_busy  = (r_state != ANIM_IDLE) | r_pending;

endmodule

// File: rtl/dog_draw.sv
// Dog sprite overlay: ROM addressing, 3-cycle pixel pipeline that absorbs
// the ROM's 1-cycle read latency, colour-keyed compositing.
module dog_draw
    import dog_pkg::*;
#(
    parameter int          SPR_W           = DOG_W,
    parameter int          SPR_H           = DOG_H,
    parameter logic [11:0] TRANSPARENT     = DOG_TRANSPARENT,
    parameter int          FRAMES_PER_STEP = DOG_FRAMES_PER_STEP
) (
    input logic         clk,
    input logic         rst,
    dog_draw_if.slave   bus
);

    vga_timing_t w_tim_in;
    logic        w_in_box;
    logic [10:0] w_dx, w_dy;
    logic [14:0] w_addr;
    logic        w_draw;
    anim_state_t w_state;
    logic        w_busy;

    vga_timing_t r_tim1, r_tim2, r_tim3;
    logic [11:0] r_rgb1, r_rgb2, r_rgb_out;
    logic        r_in_box1, r_in_box2;
    logic [14:0] r_rom_addr;

    assign w_tim_in = {bus.hcount_in, bus.vcount_in, bus.hsync_in,
                       bus.vsync_in, bus.hblnk_in, bus.vblnk_in};

    assign w_in_box = in_span(bus.hcount_in, bus.xpos, 12'(SPR_W)) &&
                      in_span(bus.vcount_in, bus.ypos, 12'(SPR_H));

    assign w_dx   = bus.hcount_in - bus.xpos;
    assign w_dy   = bus.vcount_in - bus.ypos;
    assign w_addr = 15'(16'(w_dy) * 16'(SPR_W) + 16'(w_dx));

    // Draw the ROM pixel only inside the sprite, off the colour key and in the active area.
    assign w_draw = r_in_box2 && (bus.rom_rgb != TRANSPARENT) &&
                    !r_tim2.hblnk && !r_tim2.vblnk;

    // Stage 1: ROM address and first copy of the pixel stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_tim1     <= '0;
            r_rgb1     <= '0;
            r_in_box1  <= 1'b0;
        end else begin
            r_rom_addr <= w_in_box ? w_addr : 15'd0;
            r_tim1     <= w_tim_in;
            r_rgb1     <= bus.rgb_in;
            r_in_box1  <= w_in_box;
        end
    end

    // Stage 2: wait alongside the ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tim2    <= '0;
            r_rgb2    <= '0;
            r_in_box2 <= 1'b0;
        end else begin
            r_tim2    <= r_tim1;
            r_rgb2    <= r_rgb1;
            r_in_box2 <= r_in_box1;
        end
    end

    // Stage 3: composite sprite over background and register the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tim3    <= '0;
            r_rgb_out <= '0;
        end else begin
            r_tim3    <= r_tim2;
            r_rgb_out <= w_draw ? bus.rom_rgb : r_rgb2;
        end
    end

    dog_anim_fsm #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_anim (
        .clk           (clk),
        .rst           (rst),
        .i_vblnk       (bus.vblnk_in),
        .i_throw_start (bus.throw_start),
        .o_state       (w_state),
        .o_busy        (w_busy)
    );

    assign bus.rom_addr   = r_rom_addr;
    assign bus.rom_state  = w_state;
    assign bus.busy       = w_busy;
    assign bus.hcount_out = r_tim3.hcount;
    assign bus.vcount_out = r_tim3.vcount;
    assign bus.hsync_out  = r_tim3.hsync;
    assign bus.vsync_out  = r_tim3.vsync;
    assign bus.hblnk_out  = r_tim3.hblnk;
    assign bus.vblnk_out  = r_tim3.vblnk;
    assign bus.rgb_out    = r_rgb_out;

endmodule
